// File: rtl/mem_arbiter.sv
// Shares one req/ack memory port between fetch (I) and load/store (D); D wins ties unless I has starved.
// Latency: grant registered 1 cycle after the request is sampled; response pulse 1 cycle after mem_ack; 3 cycles minimum per access.
// Backpressure: requesters hold req until their valid pulse; mem_req and all mem_* fields are held until mem_ack.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  // load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    starve_cnt, starve_nxt;
  logic                mem_req_nxt;
  logic                mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic [BE_W-1:0]     mem_be_nxt;
  logic [DATA_W-1:0]   i_rdata_nxt, d_rdata_nxt;
  logic                i_valid_nxt, d_valid_nxt;

  // Arbitration decision: D wins unless both are asking and I has waited out its budget.
  logic i_starved;
  logic grant_d;
  logic grant_i;

  assign i_starved = (starve_cnt == CNT_MAX);
  assign grant_d   = d_req && !(i_req && i_starved);
  assign grant_i   = i_req && !grant_d;

  // Next-state and next-output logic; everything not touched below holds its value.
  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_be_nxt    = mem_be;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    i_valid_nxt   = 1'b0;
    d_valid_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          mem_be_nxt    = d_be;
          state_nxt     = BUSY_D;
          // only a grant that made I wait counts against it
          if (i_req && (starve_cnt != CNT_MAX)) begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end else if (grant_i) begin
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = i_addr;
          mem_wdata_nxt = '0;
          mem_be_nxt    = '1;
          starve_nxt    = '0;
          state_nxt     = BUSY_I;
        end
      end

      BUSY_I: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          i_rdata_nxt = mem_rdata;
          i_valid_nxt = 1'b1;
          state_nxt   = RESP;
        end
      end

      BUSY_D: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          // stores return no data; hand back zero rather than whatever the bus drove
          d_rdata_nxt = mem_we ? '0 : mem_rdata;
          d_valid_nxt = 1'b1;
          state_nxt   = RESP;
        end
      end

      RESP: begin
        // valid pulse is on the outputs this cycle; requests are not looked at
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_be     <= mem_be_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_valid    <= i_valid_nxt;
      d_valid    <= d_valid_nxt;
    end
  end

endmodule
